// File: rtl/div_pkg.sv
// div_pkg: shared widths, iteration counter width and FSM state type for seq_div8by4
package div_pkg;
  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;
  localparam int CNT_W = $clog2(DVD_W_DEF) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in next dividend bit, trial subtract)
module div_step
  import div_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] rem_out,
  output logic             q_bit
);
  logic [DVS_W:0] trial;
  assign trial = {rem_in, bit_in};
  assign q_bit = trial >= {1'b0, divisor};
  // rem_in < divisor keeps a successful difference inside DVS_W bits
  assign rem_out = q_bit ? trial[DVS_W-1:0] - divisor : trial[DVS_W-1:0];
endmodule

// File: rtl/seq_div8by4.sv
// seq_div8by4: sequential unsigned restoring divider, one quotient bit per cycle.
// DIV_ZERO_DETECT_EN: a zero divisor skips RUN and flags div_zero.
module seq_div8by4
  import div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_zero
);
  state_t state, state_n;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q, rem_q, rem_n;
  logic [CNT_W-1:0] cnt;
  logic q_bit, go, zero_skip, last;
  assign go = start && state != RUN;
  assign last = cnt == '0;
  assign busy = state == RUN;
  assign done = state == DONE;
`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = divisor == '0;
  always_ff @(posedge clk)
    if (rst) div_zero <= 1'b0;
    else if (go && zero_skip) div_zero <= 1'b1;
    else if (state == RUN && last) div_zero <= 1'b0;
`else
  assign zero_skip = 1'b0;
  assign div_zero = 1'b0;
`endif
  div_step #(.DVS_W(DVS_W)) u_step (
    .rem_in (rem_q),
    .bit_in (dvd_q[DVD_W-1]),
    .divisor(dvs_q),
    .rem_out(rem_n),
    .q_bit  (q_bit)
  );
  always_comb begin
    state_n = state;
    if (go) state_n = zero_skip ? DONE : RUN;
    else if (state == DONE) state_n = IDLE;
    else if (state == RUN && last) state_n = DONE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // dvd_q doubles as the quotient shift register while RUN consumes dividend bits
  always_ff @(posedge clk)
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
    end else if (go) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      cnt <= CNT_W'(DVD_W - 1);
      if (zero_skip) begin
        quotient <= '1;
        remainder <= dividend[DVS_W-1:0];
      end
    end else if (state == RUN) begin
      dvd_q <= {dvd_q[DVD_W-2:0], q_bit};
      rem_q <= rem_n;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        quotient <= {dvd_q[DVD_W-2:0], q_bit};
        remainder <= rem_n;
      end
    end
endmodule

// File: tb/tb_seq_div8by4.sv
// tb_seq_div8by4: directed self-checking bench for seq_div8by4
module tb_seq_div8by4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, quotient;
  logic [3:0] divisor = '0, remainder;
  logic busy, done, div_zero;
  int errs = 0, checks = 0;
  int edges, busy_n, seen;

  seq_div8by4 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int e, output int b);
    e = 1;
    b = 0;
    while (!done && e < 40) begin
      b += int'(busy);
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] d, output int e, output int b);
    @(negedge clk);
    dividend = a;
    divisor = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(e, b);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk) rst = 1'b0;

    run_op(8'h1E, 4'h2, edges, busy_n);
    check("t1_edges", edges, 9);
    check("t1_done", done, 1);
    check("t1_q", quotient, 8'h0F);
    check("t1_r", remainder, 4'h0);
    check("t1_dz", div_zero, 0);
    @(posedge clk);
    #1;
    check("t1_pulse", done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_hold_q", quotient, 8'h0F);

    run_op(8'hFF, 4'h7, edges, busy_n);
    check("t2_edges", edges, 9);
    check("t2_busy_cycles", busy_n, 8);
    check("t2_q", quotient, 8'h24);
    check("t2_r", remainder, 4'h3);

    run_op(8'hA5, 4'h0, edges, busy_n);
    check("t3_q", quotient, 8'hFF);
    check("t3_r", remainder, 4'h5);
`ifdef DIV_ZERO_DETECT_EN
    check("t3_edges", edges, 1);
    check("t3_dz", div_zero, 1);
`else
    check("t3_edges", edges, 9);
    check("t3_dz", div_zero, 0);
`endif

    @(negedge clk);
    dividend = 8'h64;
    divisor = 4'h5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_busy_mid", busy, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_q", quotient, 0);
    check("t4_r", remainder, 0);
    check("t4_dz", div_zero, 0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 seen += int'(done);
    end
    check("t4_no_done", seen, 0);
    run_op(8'h64, 4'h5, edges, busy_n);
    check("t4_edges", edges, 9);
    check("t4_q2", quotient, 8'h14);
    check("t4_r2", remainder, 4'h0);

    @(negedge clk);
    dividend = 8'h1E;
    divisor = 4'h2;
    start = 1'b1;
    @(posedge clk);
    #1;
    dividend = 8'hFF;
    divisor = 4'h7;
    wait_done(edges, busy_n);
    check("t5_edges1", edges, 9);
    check("t5_q1", quotient, 8'h0F);
    check("t5_r1", remainder, 4'h0);
    @(posedge clk);
    #1 start = 1'b0;
    check("t5_b2b_busy", busy, 1);
    check("t5_b2b_done", done, 0);
    wait_done(edges, busy_n);
    check("t5_edges2", edges, 9);
    check("t5_q2", quotient, 8'h24);
    check("t5_r2", remainder, 4'h3);

    for (int a = 0; a < 256; a++)
      for (int d = 1; d < 16; d++) begin
        run_op(8'(a), 4'(d), edges, busy_n);
        check($sformatf("sweep_id %0h/%0h", a, d), 32'(quotient) * 32'(d) + 32'(remainder), 32'(a));
        check($sformatf("sweep_lt %0h/%0h", a, d), 32'(remainder < 4'(d)), 32'd1);
      end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seq_div8by4.md
SEQ_DIV8BY4 -- requirements
Module: seq_div8by4

Interface
REQ-001 SHALL have parameter DVD_W, default 8, dividend and quotient width.
REQ-002 SHALL have parameter DVS_W, default 4, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a division; sampled only when idle or done.
REQ-006 SHALL have port dividend  input  DVD_W  numerator, unsigned.
REQ-007 SHALL have port divisor  input  DVS_W  denominator, unsigned.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient  output  DVD_W  result, held until the next accepted start.
REQ-011 SHALL have port remainder  output  DVS_W  result, held until the next accepted start.
REQ-012 SHALL have port div_zero  output  1  divisor-was-zero flag, valid with done.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL latch dividend and divisor on the edge where start=1 in IDLE or DONE, then enter RUN.
REQ-015 SHALL ignore start while in RUN; latched operands stay unchanged.
REQ-016 SHALL perform unsigned restoring division in RUN, one quotient bit per cycle, MSB first.
REQ-017 SHALL use a DVS_W+1-bit partial remainder for each trial subtraction.
REQ-018 SHALL stay in RUN for exactly DVD_W cycles, then enter DONE.
REQ-019 SHALL assert done for exactly one cycle, in the cycle after the last RUN edge.
- Latency: done is high after the (DVD_W+1)th edge following the start edge; 9 edges at default widths.
REQ-020 SHALL return from DONE to IDLE unless start=1, in which case it goes directly to RUN (back-to-back).
REQ-021 SHALL drive busy=1 in RUN only.
REQ-022 SHALL update quotient and remainder only at the transition into DONE.
REQ-023 SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for any divisor != 0.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, enter IDLE and clear busy, done, quotient, remainder, div_zero and all internal state to 0.
REQ-025 SHALL give rst priority over start, including when reset is asserted mid-RUN; the aborted operation produces no done pulse.

Configuration
REQ-026 SHALL honour macro DIV_ZERO_DETECT_EN.
- Defined: divisor==0 at start skips RUN and enters DONE on the next edge (done 1 edge after start); outputs quotient={DVD_W{1}}, remainder=dividend[DVS_W-1:0], div_zero=1.
- Defined: div_zero=0 for any non-zero divisor.
- Undefined: div_zero is tied 0 and divisor==0 runs the normal DVD_W-cycle algorithm, yielding quotient={DVD_W{1}} and remainder=dividend[DVS_W-1:0].

Structure
REQ-027 SHALL place the following in shared package div_pkg:
- the DVD_W and DVS_W defaults;
- the FSM state typedef (IDLE/RUN/DONE);
- the iteration-count width constant.
REQ-028 SHALL instantiate one combinational sub-module div_step, which performs one shift-and-trial-subtract step and returns the next partial remainder and the quotient bit.

Verification
REQ-029 Bench SHALL cover: dividend=0x1E, divisor=0x2 -> after 9 edges done=1, quotient=0x0F, remainder=0x0, div_zero=0.
REQ-030 Bench SHALL cover: dividend=0xFF, divisor=0x7 -> quotient=0x24, remainder=0x3; busy high for 8 cycles.
REQ-031 Bench SHALL cover: dividend=0xA5, divisor=0x0 -> quotient=0xFF, remainder=0x5.
- With DIV_ZERO_DETECT_EN: div_zero=1, done after 1 edge.
- Without it: div_zero=0, done after 9 edges.
REQ-032 Bench SHALL cover: start (0x64/0x5), then rst=1 at the 4th RUN edge -> all outputs 0, no done pulse; a subsequent start with 0x64/0x5 -> quotient=0x14, remainder=0x0.
REQ-033 Bench SHALL cover: start=1 held during RUN with different operands -> first result unaffected; start=1 in the DONE cycle -> back-to-back second result 9 edges later.
REQ-034 Bench SHALL cover: an exhaustive sweep of all 256x15 non-zero operand pairs -> every result matches the REQ-023 identity.
